// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage data-memory access sequencer.
// A decoded lw/sw that reaches MEM raises a registered req/ack handshake with
// data memory and freezes the upstream pipeline (pipe_hold) until the access
// completes. Load data is returned with a one-cycle rdata_valid strobe.
// Optional feature: define MEM_TIMEOUT_EN to add a BUSY watchdog that moves
// to a sticky ERR state after TIMEOUT ack-less BUSY cycles.
module mem_stall_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              stall_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pipe_hold,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              err
);

`ifdef MEM_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t state;
    state_t state_next;
    logic   start;
    logic   hold_raw;

    // An access only starts for a valid instruction that is both a stalling
    // op and an actual memory read or write.
    assign start = valid_in & stall_in & (mem_read_in | mem_write_in);

`ifdef MEM_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] busy_cnt;
    logic             timeout_hit;

    // The counter holds the number of ack-less BUSY cycles already elapsed,
    // so this is the last BUSY cycle allowed before giving up.
    assign timeout_hit = (busy_cnt == CNT_LAST);

    // Watchdog counter: cleared when entering BUSY, counts ack-less BUSY cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (state == IDLE && start) begin
            busy_cnt <= '0;
        end else if (state == BUSY && !dmem_ack && !timeout_hit) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    // Without the watchdog the BUSY state waits forever and err never rises.
    assign unused_timeout = (TIMEOUT > 0);
    assign err            = 1'b0;
`endif

    // Reset drops the hold immediately, even if a start is still presented.
    assign pipe_hold = hold_raw & ~reset;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and pipeline hold; hold is combinational so the
    // starting instruction is frozen in the same cycle it is seen.
    always_comb begin
        state_next = state;
        hold_raw   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    hold_raw   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                hold_raw = 1'b1;
                if (dmem_ack) begin
                    state_next = DONE;
`ifdef MEM_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_next = ERR;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            ERR: begin
                state_next = ERR;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory-side registers: latch the request on start, hold it stable
    // through BUSY, capture load data and strobe valid on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err         <= 1'b0;
`endif
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_in;
                        dmem_addr  <= addr_in;
                        dmem_wdata <= wdata_in;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            rdata_out   <= dmem_rdata;
                            rdata_valid <= 1'b1;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        err      <= 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
